// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b code tables and constants for the multi-lane encoder.
// Sub-blocks are returned in their RD- form; the lane encoder complements them when needed.
package enc8b10b_pkg;

  localparam logic [7:0] K28_5  = 8'hBC;
  localparam logic [7:0] K28_0  = 8'h1C;
  localparam logic       RD_NEG = 1'b0;
  localparam logic       RD_POS = 1'b1;

  // abcdei, a in bit 5
  function automatic logic [5:0] enc_5b6b(input logic [4:0] x);
    logic [5:0] r;
    case (x)
      5'd0:  r = 6'b100111;
      5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;
      5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;
      5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;
      5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;
      5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;
      5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;
      5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;
      5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;
      5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;
      5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;
      5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;
      5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;
      5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;
      5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;
      5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;
      default: r = 6'b101011;
    endcase
    return r;
  endfunction

  // fghj, f in bit 3; alt7 selects A7 instead of P7 for y=7
  function automatic logic [3:0] enc_3b4b(input logic [2:0] y, input logic alt7);
    logic [3:0] r;
    case (y)
      3'd0: r = 4'b1011;
      3'd1: r = 4'b1001;
      3'd2: r = 4'b0101;
      3'd3: r = 4'b1100;
      3'd4: r = 4'b1101;
      3'd5: r = 4'b1010;
      3'd6: r = 4'b0110;
      default: r = alt7 ? 4'b0111 : 4'b1110;
    endcase
    return r;
  endfunction

  function automatic logic k_valid(input logic [7:0] d);
    logic [4:0] x;
    x = d[4:0];
    if (x == K28_0[4:0])
      return 1'b1;
    return (d[7:5] == 3'd7) && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30);
  endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// Combinational single-lane 8b/10b encoder: one byte plus K flag in, one symbol and the
// disparity that follows it out.
module enc8b10b_lane
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] sym,
  output logic       rd_out,
  output logic       err
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k_ok;
  logic       is_k28;
  logic [5:0] six_neg;
  logic       six_neutral;
  logic [5:0] six;
  logic       rd6;
  logic       use_a7;
  logic [3:0] four_neg;
  logic       four_neutral;
  logic       four_flip;
  logic [3:0] four;

  assign x      = data[4:0];
  assign y      = data[7:5];
  assign k_ok   = k && k_valid(data);
  assign err    = k && !k_ok;
  assign is_k28 = k_ok && (x == 5'd28);

  assign six_neg     = is_k28 ? 6'b001111 : enc_5b6b(x);
  assign six_neutral = ($countones(six_neg) == 3);
  // D.7 is balanced yet still has two forms, so it is complemented at RD+ like unbalanced codes
  assign six = (rd_in && (!six_neutral || six_neg == 6'b111000)) ? ~six_neg : six_neg;
  assign rd6 = six_neutral ? rd_in : ~rd_in;

  assign use_a7 = (y == 3'd7) &&
                  (k_ok ||
                   (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                   ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));

  assign four_neg     = enc_3b4b(y, use_a7);
  assign four_neutral = ($countones(four_neg) == 2);
  // K.28 inverts its balanced 4b forms after the 110000 sub-block so K.28.1/.5/.7 keep the comma
  assign four_flip = rd6 ? (!four_neutral || y == 3'd3)
                         : (is_k28 && four_neutral && y != 3'd3);
  assign four   = four_flip ? ~four_neg : four_neg;
  assign rd_out = four_neutral ? rd6 : ~rd6;

  assign sym = {six, four};

endmodule

// File: rtl/enc8b10b_rd.sv
// Multi-lane 8b/10b encoder with registered output; running disparity chains lane to lane
// within a word and across words through one register.
module enc8b10b_rd
  import enc8b10b_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [8*LANES-1:0]    in_data,
  input  logic [LANES-1:0]      in_k,
  input  logic                  rd_load,
  input  logic                  rd_value,
  output logic                  out_valid,
  output logic [10*LANES-1:0]   out_data,
  output logic                  out_rd,
  output logic [LANES-1:0]      code_err
);

  logic                rd_reg;
  logic                valid_reg;
  logic [10*LANES-1:0] data_reg;
  logic [LANES-1:0]    err_reg;

  logic                rd_chain [0:LANES];
  logic [10*LANES-1:0] sym_all;
  logic [LANES-1:0]    err_all;

  // A same-cycle load seeds lane 0 directly so that word is encoded from rd_value
  assign rd_chain[0] = rd_load ? rd_value : rd_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      enc8b10b_lane u_lane (
        .data   (in_data[8*gi +: 8]),
        .k      (in_k[gi]),
        .rd_in  (rd_chain[gi]),
        .sym    (sym_all[10*gi +: 10]),
        .rd_out (rd_chain[gi+1]),
        .err    (err_all[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_reg    <= RD_NEG;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      err_reg   <= '0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= sym_all;
        err_reg  <= err_all;
        rd_reg   <= rd_chain[LANES];
      end else if (rd_load) begin
        rd_reg <= rd_value;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_rd    = rd_reg;
  assign code_err  = err_reg;

endmodule

// File: tb/tb_enc8b10b_rd.sv
// Directed bench for enc8b10b_rd: a one-lane instance walks a vector table of hand-encoded
// symbols, a two-lane instance covers chaining and same-cycle disparity load.
module tb_enc8b10b_rd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v1 = 0, ld1 = 0, rv1 = 0;
  logic [7:0]  d1 = 0;
  logic [0:0]  k1 = 0;
  logic        ov1, ord1;
  logic [9:0]  od1;
  logic [0:0]  ce1;

  logic        v2 = 0, ld2 = 0, rv2 = 0;
  logic [15:0] d2 = 0;
  logic [1:0]  k2 = 0;
  logic        ov2, ord2;
  logic [19:0] od2;
  logic [1:0]  ce2;

  enc8b10b_rd #(.LANES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_k(k1),
    .rd_load(ld1), .rd_value(rv1), .out_valid(ov1), .out_data(od1),
    .out_rd(ord1), .code_err(ce1)
  );

  enc8b10b_rd #(.LANES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .in_k(k2),
    .rd_load(ld2), .rd_value(rv2), .out_valid(ov2), .out_data(od2),
    .out_rd(ord2), .code_err(ce2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       k;
    logic [9:0] sym;
    logic       rd;
    logic       err;
  } vec_t;

  vec_t vecs [16];

  task automatic step1(input logic v, input logic [7:0] d, input logic k, input logic ld, input logic rv);
    @(negedge clk);
    v1 = v; d1 = d; k1 = k; ld1 = ld; rv1 = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic v, input logic [15:0] d, input logic [1:0] k, input logic ld, input logic rv);
    @(negedge clk);
    v2 = v; d2 = d; k2 = k; ld2 = ld; rv2 = rv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Consecutive words from reset at LANES=1; each expected RD follows from the previous row
    vecs[0]  = '{8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0}; // K.28.5 RD-
    vecs[1]  = '{8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0}; // K.28.5 RD+
    vecs[2]  = '{8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0}; // D.21.5 RD-
    vecs[3]  = '{8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0}; // D.17.7 A7 at RD-
    vecs[4]  = '{8'hB5, 1'b0, 10'b1010101010, 1'b1, 1'b0}; // D.21.5 RD+
    vecs[5]  = '{8'h00, 1'b0, 10'b0110001011, 1'b1, 1'b0}; // D.0.0 RD+
    vecs[6]  = '{8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0}; // K.28.5 RD+
    vecs[7]  = '{8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0}; // D.0.0 RD-
    vecs[8]  = '{8'h01, 1'b1, 10'b0111010100, 1'b0, 1'b1}; // K.1.0 invalid -> D.1.0
    vecs[9]  = '{8'hF7, 1'b1, 10'b1110101000, 1'b0, 1'b0}; // K.23.7 RD-
    vecs[10] = '{8'h07, 1'b0, 10'b1110001011, 1'b1, 1'b0}; // D.7.0 RD-
    vecs[11] = '{8'h07, 1'b0, 10'b0001110100, 1'b0, 1'b0}; // D.7.0 RD+
    vecs[12] = '{8'h63, 1'b0, 10'b1100011100, 1'b0, 1'b0}; // D.3.3 RD-
    vecs[13] = '{8'hEB, 1'b0, 10'b1101001110, 1'b1, 1'b0}; // D.11.7 P7 at RD-
    vecs[14] = '{8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0}; // D.11.7 A7 at RD+
    vecs[15] = '{8'h1C, 1'b1, 10'b0011110100, 1'b0, 1'b0}; // K.28.0 RD-

    #1;
    check("rst_out_valid", {31'd0, ov1}, 32'd0);
    check("rst_out_data", {22'd0, od1}, 32'd0);
    check("rst_out_rd", {31'd0, ord1}, 32'd0);
    check("rst_code_err", {31'd0, ce1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step1(1'b1, vecs[i].data, vecs[i].k, 1'b0, 1'b0);
      $display("[TB] vec %0d data=%02h k=%0d sym=%b rd=%0d err=%0d", i, vecs[i].data, vecs[i].k, od1, ord1, ce1);
      check($sformatf("vec%0d_valid", i), {31'd0, ov1}, 32'd1);
      check($sformatf("vec%0d_sym", i), {22'd0, od1}, {22'd0, vecs[i].sym});
      check($sformatf("vec%0d_rd", i), {31'd0, ord1}, {31'd0, vecs[i].rd});
      check($sformatf("vec%0d_err", i), {31'd0, ce1}, {31'd0, vecs[i].err});
    end

    // Idle word: outputs hold, out_valid drops
    step1(1'b0, 8'hB5, 1'b0, 1'b0, 1'b0);
    $display("[TB] idle sym=%b rd=%0d valid=%0d", od1, ord1, ov1);
    check("idle_valid", {31'd0, ov1}, 32'd0);
    check("idle_hold_sym", {22'd0, od1}, {22'd0, 10'b0011110100});
    check("idle_hold_rd", {31'd0, ord1}, 32'd0);

    // Disparity load without data, then K.28.5 must take the RD+ form
    step1(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    $display("[TB] rd_load rd=%0d", ord1);
    check("load_only_rd", {31'd0, ord1}, 32'd1);
    check("load_only_sym_hold", {22'd0, od1}, {22'd0, 10'b0011110100});
    step1(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    $display("[TB] after load sym=%b rd=%0d", od1, ord1);
    check("after_load_sym", {22'd0, od1}, {22'd0, 10'b1100000101});
    check("after_load_rd", {31'd0, ord1}, 32'd0);

    // Two lanes: K.28.5 pair from RD- in one cycle
    step2(1'b1, 16'hBCBC, 2'b11, 1'b0, 1'b0);
    $display("[TB] lanes2 sym=%b rd=%0d err=%b", od2, ord2, ce2);
    check("l2_lane0", {22'd0, od2[9:0]}, {22'd0, 10'b0011111010});
    check("l2_lane1", {22'd0, od2[19:10]}, {22'd0, 10'b1100000101});
    check("l2_rd", {31'd0, ord2}, 32'd0);
    check("l2_err", {30'd0, ce2}, 32'd0);

    // Same-cycle load to RD+ with a word: lane 0 starts at RD+
    step2(1'b1, 16'hBCBC, 2'b11, 1'b1, 1'b1);
    $display("[TB] lanes2 load sym=%b rd=%0d", od2, ord2);
    check("l2ld_lane0", {22'd0, od2[9:0]}, {22'd0, 10'b1100000101});
    check("l2ld_lane1", {22'd0, od2[19:10]}, {22'd0, 10'b0011111010});
    check("l2ld_rd", {31'd0, ord2}, 32'd1);

    // Mixed lanes: invalid K in lane 1 only, lane 0 data D.21.5 at RD+
    step2(1'b1, 16'h01B5, 2'b10, 1'b0, 1'b0);
    $display("[TB] lanes2 mixed sym=%b rd=%0d err=%b", od2, ord2, ce2);
    check("l2mix_lane0", {22'd0, od2[9:0]}, {22'd0, 10'b1010101010});
    check("l2mix_lane1", {22'd0, od2[19:10]}, {22'd0, 10'b1000101011});
    check("l2mix_err", {30'd0, ce2}, 32'd2);
    check("l2mix_rd", {31'd0, ord2}, 32'd1);
    step2(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stream
    step1(1'b1, 8'hF1, 1'b0, 1'b0, 1'b0);
    step1(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset sym=%b rd=%0d valid=%0d err=%0d", od1, ord1, ov1, ce1);
    check("arst_valid", {31'd0, ov1}, 32'd0);
    check("arst_data", {22'd0, od1}, 32'd0);
    check("arst_rd", {31'd0, ord1}, 32'd0);
    check("arst_err", {31'd0, ce1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step1(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    $display("[TB] post reset sym=%b rd=%0d", od1, ord1);
    check("post_rst_sym", {22'd0, od1}, {22'd0, 10'b0011111010});
    check("post_rst_rd", {31'd0, ord1}, 32'd1);
    step1(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
